// File: rtl/nibble_cpu_pkg.sv
// Shared types and constants for the 4-bit CPU fetch path.
package nibble_cpu_pkg;

  localparam int ADDR_W_DEFAULT = 12;

  // Sequencer state codes; the numeric values are exported on the debug phase port.
  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DECODE = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  // Two-byte conditional/unconditional jump opcodes. Every other opcode is a 1-byte ALU instruction.
  localparam logic [3:0] OP_JC  = 4'b0000;
  localparam logic [3:0] OP_JNC = 4'b0001;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_JNZ = 4'b1001;
  localparam logic [3:0] OP_JMP = 4'b1100;

  // Jump target: the operand nibble is the high part, the second instruction byte the low part.
  function automatic logic [11:0] jump_target(input logic [3:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/fetch_sequencer_branch_cond.sv
// Opcode classifier: flags whether an opcode is a jump and whether its condition holds.
module branch_cond
  import nibble_cpu_pkg::*;
(
  input  logic [3:0] opcode_i,
  input  logic       c_i,
  input  logic       z_i,
  output logic       is_jump_o,
  output logic       taken_o
);

  // Decode the opcode against the current carry/zero flags.
  always_comb begin
    is_jump_o = 1'b1;
    taken_o   = 1'b0;
    unique case (opcode_i)
      OP_JC:   taken_o = c_i;
      OP_JNC:  taken_o = ~c_i;
      OP_JZ:   taken_o = z_i;
      OP_JNZ:  taken_o = ~z_i;
      OP_JMP:  taken_o = 1'b1;
      default: is_jump_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-path control FSM: sequences PC counter, program ROM and fetch register,
// resolves 2-byte jumps and issues one exec strobe per 1-byte instruction.
module fetch_sequencer
  import nibble_cpu_pkg::*;
#(
  parameter int                ADDR_W       = ADDR_W_DEFAULT,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              step,
  input  logic [3:0]        instr,
  input  logic [3:0]        oprnd,
  input  logic [7:0]        program_byte,
  input  logic              c_flag,
  input  logic              z_flag,
  output logic              pc_en,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_load_addr,
  output logic              fetch_en,
  output logic              exec_en,
  output logic              branch_taken,
  output logic              halted,
  output logic [1:0]        phase
);

  state_e state_q, state_d;
  logic   step_q, step_d;   // current instruction was started by a single-step
  logic   is_jump, taken;

  branch_cond u_branch_cond (
    .opcode_i  (instr),
    .c_i       (c_flag),
    .z_i       (z_flag),
    .is_jump_o (is_jump),
    .taken_o   (taken)
  );

  // State register and step latch; synchronous reset has highest priority.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  // Next-state logic: every instruction is FETCH then DECODE, and DECODE always completes.
  // NOTE: defaults assigned first so no path leaves a signal unassigned (no latch inferred).
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    unique case (state_q)
      ST_INIT:   begin
        state_d = run ? ST_FETCH : ST_HALTED;
        step_d  = 1'b0;
      end
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        state_d = (run && !step_q) ? ST_FETCH : ST_HALTED;
        step_d  = 1'b0;
      end
      ST_HALTED: begin
        if (run) begin
          state_d = ST_FETCH;
        end else if (step) begin
          state_d = ST_FETCH;
          step_d  = 1'b1;
        end
      end
    endcase
  end

  // Output decode from registered state and current inputs; reset silences every strobe.
  always_comb begin
    pc_en        = 1'b0;
    pc_load      = 1'b0;
    pc_load_addr = '0;
    fetch_en     = 1'b0;
    exec_en      = 1'b0;
    branch_taken = 1'b0;
    halted       = 1'b0;
    if (!reset) begin
      unique case (state_q)
        ST_INIT: begin
          pc_load      = 1'b1;
          pc_load_addr = RESET_VECTOR;
        end
        ST_FETCH: begin
          fetch_en = 1'b1;
          pc_en    = 1'b1;
        end
        ST_DECODE: begin
          if (!is_jump) begin
            exec_en = 1'b1;
          end else if (taken) begin
            // program_byte is the jump's second byte: PC already points past the opcode byte.
            pc_load      = 1'b1;
            pc_load_addr = ADDR_W'(jump_target(oprnd, program_byte));
            branch_taken = 1'b1;
          end else begin
            pc_en = 1'b1;   // skip the unused target byte
          end
        end
        ST_HALTED: halted = 1'b1;
      endcase
    end
  end

  // Debug phase reads INIT whenever reset is held, regardless of the registered state.
  assign phase = reset ? ST_INIT : state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: surrounds the DUT with a PC counter, ROM and
// fetch register, and compares every cycle against an instruction-level reference model.
module tb_fetch_sequencer;

  localparam logic [11:0] RV = 12'h010;

  logic        clk = 1'b0;
  logic        reset, run, step, c_flag, z_flag;
  logic [3:0]  instr, oprnd;
  logic [7:0]  program_byte;
  logic        pc_en, pc_load, fetch_en, exec_en, branch_taken, halted;
  logic [11:0] pc_load_addr;
  logic [1:0]  phase;

  fetch_sequencer #(.ADDR_W(12), .RESET_VECTOR(RV)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step),
    .instr(instr), .oprnd(oprnd), .program_byte(program_byte),
    .c_flag(c_flag), .z_flag(z_flag),
    .pc_en(pc_en), .pc_load(pc_load), .pc_load_addr(pc_load_addr),
    .fetch_en(fetch_en), .exec_en(exec_en), .branch_taken(branch_taken),
    .halted(halted), .phase(phase)
  );

  always #5 clk = ~clk;

  // ---------------- environment: ROM, PC counter, fetch register ----------------
  logic [7:0]  rom [0:4095];
  logic [11:0] pc;
  logic [11:0] fetch_log [0:63];
  int          n_fetch = 0;

  assign program_byte = rom[pc];

  always @(posedge clk) begin
    if (pc_load)     pc <= pc_load_addr;
    else if (pc_en)  pc <= pc + 12'd1;
    if (fetch_en) begin
      {instr, oprnd}          <= program_byte;
      fetch_log[n_fetch % 64] <= pc;
      n_fetch                 <= n_fetch + 1;
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model (instruction level) ----------------
  bit          m_init, m_idle, m_decode, m_one_shot, m_pc_valid, m_ir_valid;
  logic [11:0] m_pc;
  logic [7:0]  m_ir;

  function automatic bit op_is_jump(input logic [3:0] op);
    return op == 4'h0 || op == 4'h1 || op == 4'h8 || op == 4'h9 || op == 4'hC;
  endfunction

  function automatic bit op_taken(input logic [3:0] op, input logic c, input logic z);
    return (op == 4'hC) || (op == 4'h0 && c) || (op == 4'h1 && !c) ||
           (op == 4'h8 && z) || (op == 4'h9 && !z);
  endfunction

  task automatic compare();
    logic [5:0]  e_str;   // {pc_en, pc_load, fetch_en, exec_en, branch_taken, halted}
    logic [11:0] e_addr;
    logic [1:0]  e_ph;
    e_str  = 6'b000000;
    e_addr = 12'h000;
    e_ph   = 2'd0;
    if (reset) begin
      e_ph = 2'd0;
    end else if (m_init) begin
      e_str = 6'b010000; e_addr = RV; e_ph = 2'd0;
    end else if (m_idle) begin
      e_str = 6'b000001; e_ph = 2'd3;
    end else if (!m_decode) begin
      e_str = 6'b101000; e_ph = 2'd1;
    end else begin
      e_ph = 2'd2;
      if (!op_is_jump(m_ir[7:4]))                  e_str = 6'b000100;
      else if (op_taken(m_ir[7:4], c_flag, z_flag)) begin
        e_str = 6'b010010; e_addr = {m_ir[3:0], rom[m_pc]};
      end else                                     e_str = 6'b100000;
    end
    check("strobes", 32'({pc_en, pc_load, fetch_en, exec_en, branch_taken, halted}), 32'(e_str));
    check("load_addr", 32'(pc_load_addr), 32'(e_addr));
    check("phase", 32'(phase), 32'(e_ph));
    if (m_pc_valid) check("pc", 32'(pc), 32'(m_pc));
    if (m_ir_valid) check("fetch_reg", 32'({instr, oprnd}), 32'(m_ir));
  endtask

  task automatic model_update();
    logic [3:0] op;
    if (reset) begin
      m_init = 1; m_idle = 0; m_decode = 0; m_one_shot = 0;
    end else if (m_init) begin
      m_init = 0; m_pc = RV; m_pc_valid = 1; m_decode = 0; m_idle = !run;
    end else if (m_idle) begin
      if (run) begin
        m_idle = 0; m_decode = 0;
      end else if (step) begin
        m_idle = 0; m_decode = 0; m_one_shot = 1;
      end
    end else if (!m_decode) begin
      m_ir = rom[m_pc]; m_ir_valid = 1; m_pc = m_pc + 12'd1; m_decode = 1;
    end else begin
      op = m_ir[7:4];
      if (op_is_jump(op)) begin
        if (op_taken(op, c_flag, z_flag)) m_pc = {m_ir[3:0], rom[m_pc]};
        else                              m_pc = m_pc + 12'd1;
      end
      m_decode = 0;
      if (!run || m_one_shot) m_idle = 1;
      m_one_shot = 0;
    end
  endtask

  // One clock: drive at negedge, check shortly after, advance model at posedge.
  task automatic tick(input logic r, input logic ru, input logic st, input logic c, input logic z);
    @(negedge clk);
    reset = r; run = ru; step = st; c_flag = c; z_flag = z;
    #1;
    compare();
    @(posedge clk);
    model_update();
    cyc++;
  endtask

  task automatic expect_fetches(input string tag, input int base, input logic [11:0] exp_q[$]);
    check({tag, "_count"}, 32'(n_fetch - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check({tag, "_addr"}, 32'(fetch_log[(base + i) % 64]), 32'(exp_q[i]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   base;
    logic run_lvl;
    reset = 1'b1; run = 1'b0; step = 1'b0; c_flag = 1'b0; z_flag = 1'b0;

    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
    rom[12'h010] = 8'hA3;                          // 1-byte instruction
    rom[12'h011] = 8'h82; rom[12'h012] = 8'h00;    // JZ 200
    rom[12'h013] = 8'hC4; rom[12'h014] = 8'h56;    // JMP 456
    rom[12'h456] = 8'hCF; rom[12'h457] = 8'hFF;    // JMP FFF
    rom[12'hFFF] = 8'hC1; rom[12'h000] = 8'h23;    // JMP 123, low byte wraps to 000
    rom[12'h123] = 8'h7E;                          // 1-byte instruction

    // Free-running, z=0: JZ not taken, then JMP chain including the FFF wrap.
    tick(1, 1, 0, 0, 0);
    tick(1, 1, 0, 0, 0);
    base = n_fetch;
    repeat (13) tick(0, 1, 0, 0, 0);
    #2;
    expect_fetches("run_z0", base, '{12'h010, 12'h011, 12'h013, 12'h456, 12'hFFF, 12'h123});
    check("pc_after_run_z0", 32'(pc), 32'h124);

    // Free-running, z=1: JZ taken to 200.
    tick(1, 1, 0, 0, 1);
    base = n_fetch;
    repeat (7) tick(0, 1, 0, 0, 1);
    #2;
    expect_fetches("run_z1", base, '{12'h010, 12'h011, 12'h200});

    // Halt after INIT, then single steps.
    tick(1, 0, 0, 0, 0);
    base = n_fetch;
    repeat (4) tick(0, 0, 0, 0, 0);
    #2;
    check("halted_after_init", 32'(halted), 32'd1);
    check("pc_at_vector", 32'(pc), 32'(RV));
    tick(0, 0, 1, 0, 0);
    repeat (4) tick(0, 0, 0, 0, 0);
    #2;
    check("pc_after_step_1byte", 32'(pc), 32'h011);
    repeat (3) tick(0, 0, 1, 0, 0);                // step held: ignored outside HALTED
    repeat (3) tick(0, 0, 0, 0, 0);
    #2;
    check("pc_after_step_jz_nt", 32'(pc), 32'h013);
    check("halted_after_step", 32'(halted), 32'd1);
    expect_fetches("step", base, '{12'h010, 12'h011});

    // Reset asserted during the DECODE of the JMP at 013.
    tick(1, 1, 0, 0, 0);
    repeat (6) tick(0, 1, 0, 0, 0);                // INIT, F010, D, F011, D, F013
    @(negedge clk);
    reset = 1'b1; #1;
    check("reset_mid_decode_no_load", 32'(pc_load), 32'd0);
    check("reset_mid_decode_no_branch", 32'(branch_taken), 32'd0);
    compare();
    @(posedge clk); model_update(); cyc++;
    tick(0, 1, 0, 0, 0);                           // INIT
    #2;
    check("pc_after_reinit", 32'(pc), 32'(RV));

    // Randomized run: reset, run toggling, step pulses, random flags.
    run_lvl = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) run_lvl = ~run_lvl;
      tick($urandom_range(0, 299) == 0, run_lvl, $urandom_range(0, 5) == 0,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
